// File: rtl/background_palette_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : background_palette_encoder
//  Description : Two-stage valid/ready quantizer mapping RGB444 pixels to the
//                background palette index of the nearest gray level, with a
//                saturating counter of non-gray pixels emitted.
//  Revision    : 1.0 - initial release
// ============================================================================
module background_palette_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_red,
  input  logic [3:0]       in_green,
  input  logic [3:0]       in_blue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_index,
  output logic             out_exact,
  output logic [CNT_W-1:0] nongray_count
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: channel sum and exact-gray flag
  logic             s1_valid_q, s1_valid_d;
  logic [5:0]       s1_sum_q,   s1_sum_d;
  logic             s1_exact_q, s1_exact_d;
  // Stage 2: palette index presented on the output
  logic             s2_valid_q, s2_valid_d;
  logic [3:0]       s2_index_q, s2_index_d;
  logic             s2_exact_q, s2_exact_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_out_fire;
  logic [5:0]       w_in_sum;
  logic [5:0]       w_sum_p1;
  logic [3:0]       w_level;
  logic [3:0]       w_index;

  // Inverse of the background palette: gray level -> palette index
  function automatic logic [3:0] level_to_index(input logic [3:0] level);
    logic [3:0] idx;
    case (level)
      4'h0: idx = 4'd0;
      4'h1: idx = 4'd10;
      4'h2: idx = 4'd4;
      4'h3: idx = 4'd11;
      4'h4: idx = 4'd7;
      4'h5: idx = 4'd8;
      4'h6: idx = 4'd2;
      4'h7: idx = 4'd12;
      4'h8: idx = 4'd15;
      4'h9: idx = 4'd6;
      4'hA: idx = 4'd9;
      4'hB: idx = 4'd1;
      4'hC: idx = 4'd14;
      4'hD: idx = 4'd5;
      4'hE: idx = 4'd13;
      default: idx = 4'd3;
    endcase
    return idx;
  endfunction

  // Handshake control: each stage advances when its successor can take data
  always_comb begin
    w_s2_load  = !s2_valid_q || out_ready;
    w_s1_load  = !s1_valid_q || w_s2_load;
    w_out_fire = s2_valid_q && out_ready && !Reset;
    in_ready   = w_s1_load && !Reset;
    out_valid  = s2_valid_q && !Reset;
    out_index  = s2_index_q;
    out_exact  = s2_exact_q;
    nongray_count = cnt_q;
  end

  // Datapath: sum of channels in S1, rounded mean and index lookup in S2.
  // (sum + 1) / 3 rounds sum/3 to nearest; sum/3 never sits on a .5 point.
  always_comb begin
    w_in_sum = {2'b00, in_red} + {2'b00, in_green} + {2'b00, in_blue};
    w_sum_p1 = s1_sum_q + 6'd1;
    w_level  = 4'(w_sum_p1 / 6'd3);
    w_index  = level_to_index(w_level);
  end

  // Next-state: a loading stage copies its predecessor, including its valid
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_exact_d = s1_exact_q;
    s2_valid_d = s2_valid_q;
    s2_index_d = s2_index_q;
    s2_exact_d = s2_exact_q;
    cnt_d      = cnt_q;
    if (w_s1_load) begin
      s1_valid_d = in_valid;
      s1_sum_d   = w_in_sum;
      s1_exact_d = (in_red == in_green) && (in_green == in_blue);
    end
    if (w_s2_load) begin
      s2_valid_d = s1_valid_q;
      s2_index_d = w_index;
      s2_exact_d = s1_exact_q;
    end
    if (w_out_fire && !s2_exact_q && (cnt_q != c_CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pipeline and counter registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_exact_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_index_q <= '0;
      s2_exact_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_exact_q <= s1_exact_d;
      s2_valid_q <= s2_valid_d;
      s2_index_q <= s2_index_d;
      s2_exact_q <= s2_exact_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_background_palette_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_background_palette_encoder
//  Description : Directed self-checking bench for background_palette_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_background_palette_encoder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       r = '0, g = '0, b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_index;
  logic             out_exact;
  logic [CNT_W-1:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-written palette inverse: gray level -> index
  logic [3:0] c_map [16] = '{4'd0, 4'd10, 4'd4, 4'd11, 4'd7, 4'd8, 4'd2, 4'd12,
                             4'd15, 4'd6, 4'd9, 4'd1, 4'd14, 4'd5, 4'd13, 4'd3};

  background_palette_encoder #(.CNT_W(CNT_W)) dut (
    .Clk          (clk),
    .Reset        (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_red       (r),
    .in_green     (g),
    .in_blue      (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_exact    (out_exact),
    .nongray_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
    in_valid = v; r = rr; g = gg; b = bb;
  endtask

  // Samples handshakes just before the edge, then advances one clock
  task automatic tick(output bit fi, output bit fo, output logic [3:0] oi, output logic oe);
    #1;
    fi = in_valid && in_ready;
    fo = out_valid && out_ready;
    oi = out_index;
    oe = out_exact;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] model(input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
    int s;
    s = int'(rr) + int'(gg) + int'(bb);
    return {c_map[(s + 1) / 3], (rr == gg) && (gg == bb)};
  endfunction

  initial begin
    bit         fi, fo;
    logic [3:0] oi;
    logic       oe;
    int         sent, got, mcnt;
    logic [4:0] sb[$];
    logic [4:0] e;
    logic [3:0] rnd_r [4] = '{4'd1, 4'd1, 4'd15, 4'd8};
    logic [3:0] rnd_g [4] = '{4'd0, 4'd1, 4'd15, 4'd0};
    logic [3:0] rnd_b [4] = '{4'd0, 4'd0, 4'd14, 4'd0};
    logic [3:0] rnd_i [4] = '{4'd0, 4'd10, 4'd3, 4'd11};

    // Reset state
    out_ready = 1'b1;
    drive(1'b1, 4'd5, 4'd5, 4'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_exact", out_exact, 0);
    chk("rst_count", cnt, 0);
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single white pixel
    drive(1'b1, 4'hF, 4'hF, 4'hF);
    tick(fi, fo, oi, oe);
    chk("fff_accept", fi, 1);
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    chk("fff_not_yet_valid", out_valid, 0);
    tick(fi, fo, oi, oe);
    chk("fff_valid", out_valid, 1);
    chk("fff_index", out_index, 3);
    chk("fff_exact", out_exact, 1);
    tick(fi, fo, oi, oe);
    chk("fff_fire", fo, 1);
    chk("fff_drained", out_valid, 0);
    chk("fff_count", cnt, 0);

    // Sweep of all 16 grays back to back
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(1'b1, 4'(k), 4'(k), 4'(k));
      else        drive(1'b0, 4'd0, 4'd0, 4'd0);
      tick(fi, fo, oi, oe);
      if (k < 16) chk("sweep_accept", fi, 1);
      if (k >= 2) begin
        chk("sweep_fire", fo, 1);
        chk("sweep_index", oi, c_map[k-2]);
        chk("sweep_exact", oe, 1);
      end
    end
    chk("sweep_count", cnt, 0);

    // Rounding corners
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, rnd_r[k], rnd_g[k], rnd_b[k]);
      else       drive(1'b0, 4'd0, 4'd0, 4'd0);
      tick(fi, fo, oi, oe);
      if (k >= 2) begin
        chk("round_fire", fo, 1);
        chk("round_index", oi, rnd_i[k-2]);
        chk("round_exact", oe, 0);
      end
    end
    chk("round_count", cnt, 4);

    // Backpressure: out_ready low for 5 cycles while 6 grays are offered
    sent = 0; got = 0;
    for (int c = 0; c < 25; c++) begin
      out_ready = (c >= 5);
      if (sent < 6) drive(1'b1, 4'(sent + 1), 4'(sent + 1), 4'(sent + 1));
      else          drive(1'b0, 4'd0, 4'd0, 4'd0);
      tick(fi, fo, oi, oe);
      if (fi) sent++;
      if (c >= 2 && c <= 4) begin
        chk("bp_stall_ready", fi, 0);
        chk("bp_hold_index", oi, c_map[1]);
      end
      if (c == 4) chk("bp_accepts_stalled", sent, 2);
      if (c == 5) chk("bp_release_ready", fi, 1);
      if (fo) begin
        chk("bp_order", oi, c_map[got + 1]);
        got++;
      end
    end
    chk("bp_sent", sent, 6);
    chk("bp_got", got, 6);

    // Saturation at 15, then reset mid-stream
    rst = 1'b1;
    tick(fi, fo, oi, oe);
    rst = 1'b0;
    chk("sat_start", cnt, 0);
    out_ready = 1'b1;
    for (int j = 0; j < 22; j++) begin
      if (j < 20) drive(1'b1, 4'd1, 4'd0, 4'd0);
      else        drive(1'b0, 4'd0, 4'd0, 4'd0);
      tick(fi, fo, oi, oe);
    end
    chk("sat_count", cnt, 15);
    drive(1'b1, 4'd2, 4'd0, 4'd0);
    repeat (3) tick(fi, fo, oi, oe);
    chk("sat_full_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_no_out_valid", out_valid, 0);
    tick(fi, fo, oi, oe);
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 4'd0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", cnt, 0);
    for (int j = 0; j < 4; j++) begin
      tick(fi, fo, oi, oe);
      chk("midrst_no_stale", fo, 0);
    end

    // Random valid/ready traffic against a scoreboard
    sent = 0; got = 0; mcnt = 0;
    for (int c = 0; c < 20000 && got < 2000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive((sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        e = model(r, r, r);
        g = r; b = r;
      end
      tick(fi, fo, oi, oe);
      if (fi) begin
        sb.push_back(model(r, g, b));
        sent++;
      end
      if (fo) begin
        if (sb.size() == 0) begin
          chk("rand_spurious", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rand_index", oi, e[4:1]);
          chk("rand_exact", oe, e[0]);
          if (!e[0] && mcnt < 15) mcnt++;
        end
        got++;
      end
    end
    chk("rand_got", got, 2000);
    chk("rand_count", cnt, mcnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
